regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the NPC core; successor to the 2R/1W file.
//  Provides NUM_RD combinational read ports, two write ports (ALU writeback wb0, load/CSR writeback wb1),
//  optional write-to-read bypass, a per-register busy scoreboard for issue hazard checks,
//  and a sequenced post-reset clear (one entry per cycle) instead of a single-cycle flash clear.
// PARAMETERS
//  DATA_W    64  register width in bits
//  ADDR_W    5   index width; DEPTH = 2**ADDR_W entries
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: entry 0 hardwired to zero (reads 0, writes/reserve dropped); 0: entry 0 is ordinary
//  BYPASS    1   1: a same-cycle write is forwarded to matching reads; 0: reads see array contents only
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               synchronous, active-high reset
//  ready      out  1               1 once the clear sequence has finished
//  rd_addr    in   NUM_RD*ADDR_W   read indices, port i at [i*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*DATA_W   read data, port i at [i*DATA_W +: DATA_W]
//  rd_busy    out  NUM_RD          scoreboard bit of rd_addr[i] (after same-cycle writeback clear)
//  wb0_en     in   1               write port 0 enable
//  wb0_addr   in   ADDR_W          write port 0 index
//  wb0_data   in   DATA_W          write port 0 data
//  wb1_en     in   1               write port 1 enable (higher priority)
//  wb1_addr   in   ADDR_W          write port 1 index
//  wb1_data   in   DATA_W          write port 1 data
//  rsv_en     in   1               reserve destination at issue (set busy)
//  rsv_addr   in   ADDR_W          index to reserve
// BEHAVIOUR
//  - FSM states CLEAR, READY. rst=1 (any state, any cycle) -> CLEAR, clr_idx<=0, all busy<=0, ready<=0.
//  - CLEAR: entry[clr_idx]<=0 each cycle, clr_idx++; after writing DEPTH-1 -> READY next edge.
//    ready rises exactly DEPTH cycles after the first cycle with rst=0 (32 for ADDR_W=5).
//  - In CLEAR: rd_data=0, rd_busy=0, wb*/rsv inputs ignored. READY holds until the next rst.
//  - Writes (READY): entry written at posedge when wbN_en=1. Same index on both ports: wb1_data wins.
//  - ZERO_REG=1: writes/reserves to index 0 dropped; reads of index 0 return 0, busy 0.
//  - Reads combinational, 0-cycle latency. BYPASS=1: rd_data = wb1_data if wb1 hits, else wb0_data
//    if wb0 hits, else array. BYPASS=0: array only (write is visible the cycle after).
//  - Scoreboard: busy[i] cleared by any wbN_en to i; set by rsv_en to i.
//    Same-cycle clear and set on one index: set wins (busy stays 1).
//  - rd_busy[i] = busy[rd_addr[i]] AND NOT (same-cycle writeback to rd_addr[i]) when BYPASS=1;
//    raw busy bit when BYPASS=0.
//  - Reset mid-clear restarts the sequence from index 0. Entries hold undefined data until cleared;
//    rd_data is forced to 0 during CLEAR, so undefined data is never visible.
//  - Index arithmetic is ADDR_W wide; clr_idx terminal test is clr_idx == DEPTH-1, with no wrap past it.
// TESTING
//  1 rst 1 cycle, then idle -> ready=0 for 32 cycles, 1 on the 33rd; every read returns 0 afterwards.
//  2 wb0 x5<=0xA, wb1 x5<=0xB same cycle, read x5 same cycle -> 0xB (BYPASS=1); next cycle -> 0xB.
//  3 ZERO_REG=1: wb0 x0<=0xFFFF, rsv x0 -> rd_data x0 = 0 and rd_busy = 0, both that cycle and the next.
//  4 rsv x7; next cycle rd_busy=1; wb0 x7<=0x42 with rsv x7 same cycle -> data 0x42, busy stays 1.
//  5 rst at clear cycle 10, held 1 cycle -> ready rises 32 cycles later; a write during CLEAR has no effect.
//  6 BYPASS=0, NUM_RD=3: write x3<=0x99 -> read x3 shows old value that cycle, 0x99 on the next edge.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bundle of read, writeback and reserve signals for the multi-port register file.
// The master side is the core pipeline; the slave side is regfile_mp.
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wb0_en;
  logic [ADDR_W-1:0]        wb0_addr;
  logic [DATA_W-1:0]        wb0_data;
  logic                     wb1_en;
  logic [ADDR_W-1:0]        wb1_addr;
  logic [DATA_W-1:0]        wb1_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
           rsv_en, rsv_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
           rsv_en, rsv_addr
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational reads, two writeback ports,
// optional write-to-read bypass, busy scoreboard and a one-entry-per-cycle post-reset clear.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e             state_q;
  logic               ready_q;
  logic [ADDR_W-1:0]  clr_idx_q;
  logic [DEPTH-1:0]   busy_q;
  logic [DEPTH-1:0]   busy_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic active;
  logic we0;
  logic we1;
  logic rsv_ok;
  logic clr_we;

  // Entry 0 is silently dropped as a target when it is hardwired to zero.
  assign active = (state_q == READY) && !rst;
  assign we0    = active && bus.wb0_en && !((ZERO_REG != 0) && (bus.wb0_addr == '0));
  assign we1    = active && bus.wb1_en && !((ZERO_REG != 0) && (bus.wb1_addr == '0));
  assign rsv_ok = active && bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));
  assign clr_we = (state_q == CLEAR) && !rst;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (we0)    busy_d[bus.wb0_addr] = 1'b0;
    if (we1)    busy_d[bus.wb1_addr] = 1'b0;
    if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      ready_q   <= 1'b0;
      clr_idx_q <= '0;
      busy_q    <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + ADDR_W'(1);
          end
        end
        READY: begin
          busy_q <= busy_d;
        end
        default: begin
          state_q <= CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset; the clear sequence zeroes it one entry
  // per cycle and reads are forced to zero until that sequence has finished.
  // Port 1 is written last so it wins when both ports target the same entry.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx_q] <= '0;
    end else begin
      if (we0) mem_q[bus.wb0_addr] <= bus.wb0_data;
      if (we1) mem_q[bus.wb1_addr] <= bus.wb1_data;
    end
  end

  assign bus.ready = ready_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit0;
    logic              hit1;
    logic              zero_hit;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr     = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign hit0     = (BYPASS != 0) && we0 && (bus.wb0_addr == addr);
    assign hit1     = (BYPASS != 0) && we1 && (bus.wb1_addr == addr);
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);

    // A writeback landing this cycle both forwards its data and frees the entry.
    always_comb begin
      data = mem_q[addr];
      busy = busy_q[addr];
      if ((state_q != READY) || zero_hit) begin
        data = '0;
        busy = 1'b0;
      end else begin
        if (hit1)      data = bus.wb1_data;
        else if (hit0) data = bus.wb0_data;
        if (hit0 || hit1) busy = 1'b0;
      end
    end

    assign bus.rd_data[p*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[p]                  = busy;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: two instances (bypass/zero-reg 2-port and
// plain 3-port) checked every cycle against an array-based model of the file.
module tb_regfile_mp;
  logic clk;
  logic rst;

  logic        wb0_en   [2];
  logic [4:0]  wb0_addr [2];
  logic [63:0] wb0_data [2];
  logic        wb1_en   [2];
  logic [4:0]  wb1_addr [2];
  logic [63:0] wb1_data [2];
  logic        rsv_en   [2];
  logic [4:0]  rsv_addr [2];
  logic [4:0]  rd_addr  [2][3];

  logic [63:0] obs_data  [2][3];
  logic        obs_busy  [2][3];
  logic        obs_ready [2];

  // Reference model: d=0 has bypass and hardwired x0, d=1 has neither.
  logic [63:0] m_mem   [2][32];
  logic        m_busy  [2][32];
  logic        m_ready [2];
  int          m_cnt   [2];

  int  n_pass;
  int  n_total;
  bit  chk_en;

  regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(3)) bus_b ();

  regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign bus_a.wb0_en   = wb0_en[0];
  assign bus_a.wb0_addr = wb0_addr[0];
  assign bus_a.wb0_data = wb0_data[0];
  assign bus_a.wb1_en   = wb1_en[0];
  assign bus_a.wb1_addr = wb1_addr[0];
  assign bus_a.wb1_data = wb1_data[0];
  assign bus_a.rsv_en   = rsv_en[0];
  assign bus_a.rsv_addr = rsv_addr[0];
  assign bus_a.rd_addr  = {rd_addr[0][1], rd_addr[0][0]};

  assign bus_b.wb0_en   = wb0_en[1];
  assign bus_b.wb0_addr = wb0_addr[1];
  assign bus_b.wb0_data = wb0_data[1];
  assign bus_b.wb1_en   = wb1_en[1];
  assign bus_b.wb1_addr = wb1_addr[1];
  assign bus_b.wb1_data = wb1_data[1];
  assign bus_b.rsv_en   = rsv_en[1];
  assign bus_b.rsv_addr = rsv_addr[1];
  assign bus_b.rd_addr  = {rd_addr[1][2], rd_addr[1][1], rd_addr[1][0]};

  assign obs_ready[0] = bus_a.ready;
  assign obs_ready[1] = bus_b.ready;
  for (genvar p = 0; p < 2; p++) begin : g_obs_a
    assign obs_data[0][p] = bus_a.rd_data[p*64 +: 64];
    assign obs_busy[0][p] = bus_a.rd_busy[p];
  end
  assign obs_data[0][2] = '0;
  assign obs_busy[0][2] = 1'b0;
  for (genvar p = 0; p < 3; p++) begin : g_obs_b
    assign obs_data[1][p] = bus_b.rd_data[p*64 +: 64];
    assign obs_busy[1][p] = bus_b.rd_busy[p];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int num_rd(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic logic [63:0] exp_data(input int d, input int p);
    logic [4:0] a;
    a = rd_addr[d][p];
    if (!m_ready[d]) return 64'h0;
    if (d == 0 && a == 5'd0) return 64'h0;
    if (d == 0 && !rst) begin
      if (wb1_en[d] && wb1_addr[d] == a) return wb1_data[d];
      if (wb0_en[d] && wb0_addr[d] == a) return wb0_data[d];
    end
    return m_mem[d][a];
  endfunction

  function automatic logic exp_busy(input int d, input int p);
    logic [4:0] a;
    a = rd_addr[d][p];
    if (!m_ready[d]) return 1'b0;
    if (d == 0 && a == 5'd0) return 1'b0;
    if (d == 0 && !rst && ((wb0_en[d] && wb0_addr[d] == a) || (wb1_en[d] && wb1_addr[d] == a)))
      return 1'b0;
    return m_busy[d][a];
  endfunction

  task automatic check_model();
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("model_ready_d%0d", d), 64'(obs_ready[d]), 64'(m_ready[d]));
        for (int p = 0; p < num_rd(d); p++) begin
          check($sformatf("model_data_d%0d_p%0d", d, p), obs_data[d][p], exp_data(d, p));
          check($sformatf("model_busy_d%0d_p%0d", d, p), 64'(obs_busy[d][p]), 64'(exp_busy(d, p)));
        end
      end
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ready[d] = 1'b0;
        m_cnt[d]   = 0;
        for (int i = 0; i < 32; i++) m_busy[d][i] = 1'b0;
      end else if (!m_ready[d]) begin
        m_cnt[d]++;
        if (m_cnt[d] == 32) begin
          m_ready[d] = 1'b1;
          for (int i = 0; i < 32; i++) m_mem[d][i] = 64'h0;
        end
      end else begin
        if (wb0_en[d] && !(d == 0 && wb0_addr[d] == 5'd0)) begin
          m_mem[d][wb0_addr[d]]  = wb0_data[d];
          m_busy[d][wb0_addr[d]] = 1'b0;
        end
        if (wb1_en[d] && !(d == 0 && wb1_addr[d] == 5'd0)) begin
          m_mem[d][wb1_addr[d]]  = wb1_data[d];
          m_busy[d][wb1_addr[d]] = 1'b0;
        end
        if (rsv_en[d] && !(d == 0 && rsv_addr[d] == 5'd0))
          m_busy[d][rsv_addr[d]] = 1'b1;
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      wb0_en[d] = 1'b0; wb0_addr[d] = '0; wb0_data[d] = '0;
      wb1_en[d] = 1'b0; wb1_addr[d] = '0; wb1_data[d] = '0;
      rsv_en[d] = 1'b0; rsv_addr[d] = '0;
      for (int p = 0; p < 3; p++) rd_addr[d][p] = '0;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    chk_en  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_ready[d] = 1'b0;
      m_cnt[d]   = 0;
      for (int i = 0; i < 32; i++) begin
        m_mem[d][i]  = 64'h0;
        m_busy[d][i] = 1'b0;
      end
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Clear sequence: ready low for 32 cycles, high on the 33rd.
    for (int k = 1; k <= 32; k++) begin
      #1;
      check($sformatf("t1_ready_low_c%0d", k), 64'(obs_ready[0]), 64'h0);
      tick();
    end
    #1;
    check("t1_ready_high", 64'(obs_ready[0]), 64'h1);
    check("t1_ready_high_b", 64'(obs_ready[1]), 64'h1);
    for (int k = 0; k < 16; k++) begin
      rd_addr[0][0] = 5'(k);
      rd_addr[0][1] = 5'(k + 16);
      rd_addr[1][0] = 5'(k);
      rd_addr[1][1] = 5'(k + 16);
      rd_addr[1][2] = 5'(31 - k);
      #1;
      check($sformatf("t1_zero_a_x%0d", k), obs_data[0][0] | obs_data[0][1], 64'h0);
      check($sformatf("t1_zero_b_x%0d", k), obs_data[1][0] | obs_data[1][1] | obs_data[1][2], 64'h0);
      tick();
    end

    // Both ports to x5 in one cycle: port 1 wins, forwarded and stored.
    idle();
    wb0_en[0] = 1'b1; wb0_addr[0] = 5'd5; wb0_data[0] = 64'hA;
    wb1_en[0] = 1'b1; wb1_addr[0] = 5'd5; wb1_data[0] = 64'hB;
    rd_addr[0][0] = 5'd5; rd_addr[0][1] = 5'd5;
    #1;
    check("t2_bypass_x5", obs_data[0][0], 64'hB);
    tick();
    idle();
    rd_addr[0][1] = 5'd5;
    #1;
    check("t2_stored_x5", obs_data[0][1], 64'hB);
    tick();

    // Hardwired x0 ignores both writes and reserves.
    wb0_en[0] = 1'b1; wb0_addr[0] = 5'd0; wb0_data[0] = 64'hFFFF;
    rsv_en[0] = 1'b1; rsv_addr[0] = 5'd0;
    rd_addr[0][0] = 5'd0; rd_addr[0][1] = 5'd0;
    #1;
    check("t3_x0_data_now", obs_data[0][0], 64'h0);
    check("t3_x0_busy_now", 64'(obs_busy[0][1]), 64'h0);
    tick();
    idle();
    #1;
    check("t3_x0_data_next", obs_data[0][0], 64'h0);
    check("t3_x0_busy_next", 64'(obs_busy[0][0]), 64'h0);
    tick();

    // Reserve x7, then writeback and re-reserve x7 together: set wins.
    rsv_en[0] = 1'b1; rsv_addr[0] = 5'd7;
    tick();
    idle();
    rd_addr[0][0] = 5'd7;
    #1;
    check("t4_busy_set", 64'(obs_busy[0][0]), 64'h1);
    wb0_en[0] = 1'b1; wb0_addr[0] = 5'd7; wb0_data[0] = 64'h42;
    rsv_en[0] = 1'b1; rsv_addr[0] = 5'd7;
    #1;
    check("t4_bypass_data", obs_data[0][0], 64'h42);
    tick();
    idle();
    rd_addr[0][0] = 5'd7;
    #1;
    check("t4_data_stored", obs_data[0][0], 64'h42);
    check("t4_busy_stays", 64'(obs_busy[0][0]), 64'h1);
    tick();

    // No bypass on the 3-port file: write and raw busy visible only after the edge.
    idle();
    rsv_en[1] = 1'b1; rsv_addr[1] = 5'd3;
    tick();
    idle();
    wb0_en[1] = 1'b1; wb0_addr[1] = 5'd3; wb0_data[1] = 64'h99;
    rd_addr[1][2] = 5'd3;
    #1;
    check("t6_old_value", obs_data[1][2], 64'h0);
    check("t6_raw_busy", 64'(obs_busy[1][2]), 64'h1);
    tick();
    idle();
    rd_addr[1][2] = 5'd3;
    rd_addr[1][0] = 5'd3;
    #1;
    check("t6_new_value", obs_data[1][2], 64'h99);
    check("t6_busy_freed", 64'(obs_busy[1][0]), 64'h0);
    tick();

    // Randomized traffic on a narrow index range to provoke collisions.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        wb0_en[d]   = 1'($urandom_range(0, 1));
        wb0_addr[d] = 5'($urandom_range(0, 7));
        wb0_data[d] = {$urandom, $urandom};
        wb1_en[d]   = 1'($urandom_range(0, 1));
        wb1_addr[d] = 5'($urandom_range(0, 7));
        wb1_data[d] = {$urandom, $urandom};
        rsv_en[d]   = 1'($urandom_range(0, 1));
        rsv_addr[d] = 5'($urandom_range(0, 7));
        for (int p = 0; p < 3; p++) rd_addr[d][p] = 5'($urandom_range(0, 7));
      end
      tick();
    end

    // Reset at clear cycle 10 restarts the sequence; writes during clear are dropped.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 1) begin
        for (int d = 0; d < 2; d++) begin
          wb0_en[d] = 1'b1; wb0_addr[d] = 5'd9;  wb0_data[d] = 64'h55;
          wb1_en[d] = 1'b1; wb1_addr[d] = 5'd12; wb1_data[d] = 64'h66;
          rsv_en[d] = 1'b1; rsv_addr[d] = 5'd9;
        end
      end else begin
        idle();
      end
      #1;
      check($sformatf("t5_ready_low_c%0d", k), 64'(obs_ready[1]), 64'h0);
      tick();
    end
    idle();
    rd_addr[0][0] = 5'd9; rd_addr[0][1] = 5'd12;
    rd_addr[1][0] = 5'd9; rd_addr[1][1] = 5'd12;
    #1;
    check("t5_ready_high", 64'(obs_ready[0]), 64'h1);
    check("t5_x9_cleared", obs_data[0][0], 64'h0);
    check("t5_x12_cleared_b", obs_data[1][1], 64'h0);
    check("t5_x9_not_busy", 64'(obs_busy[1][0]), 64'h0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
